// File: rtl/cache_pkg.sv
// Shared widths, FSM state encoding and block word-order helper for the cache controller.
// Latency: none (declarations only).
// Backpressure: none.
package cache_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int TAG_W    = 4;
  localparam int INDEX_W  = 2;
  localparam int OFFSET_W = 4;
  localparam int WORDS    = 4;
  localparam int WORD_W   = 2;
  localparam int BLOCK_W  = WORDS * DATA_W;

  // One cache line; element i is word i, so element 0 sits in the low bits (memory read order).
  typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    COMPARE    = 3'd1,
    WRITE_BACK = 3'd2,
    WB_RELEASE = 3'd3,
    ALLOCATE   = 3'd4
  } state_t;

  // Reverses word order: converts between memory read order (word 0 low)
  // and memory write order (word 0 high). The operation is its own inverse.
  function automatic line_t swap_order(input line_t line);
    line_t result;
    for (int i = 0; i < WORDS; i++) begin
      result[i] = line[WORDS-1-i];
    end
    return result;
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/dirty/tag/data storage for the direct-mapped cache; one write port, combinational read.
// Latency: read is combinational on rd_index; writes take effect at the next clock edge.
// Backpressure: none; the controller FSM sequences all accesses.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output line_t              rd_line,
  input  logic               wr_word_en,
  input  logic               wr_line_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [DATA_W-1:0]  wr_word_data,
  input  logic [TAG_W-1:0]   wr_tag,
  input  line_t              wr_line_data
);

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tags [LINES];
  line_t            data [LINES];

  // Reset drops all lines; a refill installs a clean line, a store marks its line dirty.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_line_en) begin
      valid[wr_index] <= 1'b1;
      dirty[wr_index] <= 1'b0;
      tags[wr_index]  <= wr_tag;
      data[wr_index]  <= wr_line_data;
    end else if (wr_word_en) begin
      data[wr_index][wr_word] <= wr_word_data;
      dirty[wr_index]         <= 1'b1;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = data[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-back/write-allocate cache FSM between CPU word port and 128-bit block memory.
// Latency: from acceptance edge, hit ready in cycle 1, clean miss cycle 3, dirty miss cycle 5.
// Backpressure: CPU holds cpu_req until the one-cycle cpu_ready pulse; optional CACHE_STATS_EN adds hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int LINES = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cpu_req,
  input  logic               cpu_write,
  input  logic [ADDR_W-1:0]  cpu_address,
  input  logic [DATA_W-1:0]  cpu_write_data,
  output logic [DATA_W-1:0]  cpu_read_data,
  output logic               cpu_ready,
  output logic               mem_read_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BLOCK_W-1:0] mem_write_data,
  input  logic [BLOCK_W-1:0] mem_read_data
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  state_t state;
  state_t state_next;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [WORD_W-1:0]  req_word;
  logic               req_write;
  logic [DATA_W-1:0]  req_data;

  logic               rd_valid;
  logic               rd_dirty;
  logic [TAG_W-1:0]   rd_tag;
  line_t              rd_line;
  logic               wr_word_en;
  logic               wr_line_en;
  logic               hit;

  // Byte-offset bits never matter for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_address[1:0];

  assign hit = rd_valid && (rd_tag == req_tag);

  cache_line_array #(
    .LINES (LINES)
  ) u_lines (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_index     (req_index),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_line      (rd_line),
    .wr_word_en   (wr_word_en),
    .wr_line_en   (wr_line_en),
    .wr_index     (req_index),
    .wr_word      (req_word),
    .wr_word_data (req_data),
    .wr_tag       (req_tag),
    .wr_line_data (line_t'(mem_read_data))
  );

  // State register; reset abandons any transfer in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture the request only when accepted in IDLE so later CPU-side changes are ignored.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_write <= 1'b0;
      req_data  <= '0;
    end else if (state == IDLE && cpu_req) begin
      req_tag   <= cpu_address[9:6];
      req_index <= cpu_address[5:4];
      req_word  <= cpu_address[3:2];
      req_write <= cpu_write;
      req_data  <= cpu_write_data;
    end
  end

  // Next-state and outputs; memory outputs are zero outside the write-back/allocate states.
  always_comb begin
    state_next     = state;
    cpu_ready      = 1'b0;
    cpu_read_data  = '0;
    mem_read_write = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    wr_word_en     = 1'b0;
    wr_line_en     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          cpu_ready  = 1'b1;
          state_next = IDLE;
          if (req_write) wr_word_en = 1'b1;
          else           cpu_read_data = rd_line[req_word];
        end else if (rd_valid && rd_dirty) begin
          state_next = WRITE_BACK;
        end else begin
          state_next = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        mem_address    = {rd_tag, req_index, {OFFSET_W{1'b0}}};
        mem_write_data = swap_order(rd_line);
        mem_read_write = 1'b1;
        state_next     = WB_RELEASE;
      end
      WB_RELEASE: begin
        // Victim line is untouched until ALLOCATE, so address and data stay stable here.
        mem_address    = {rd_tag, req_index, {OFFSET_W{1'b0}}};
        mem_write_data = swap_order(rd_line);
        state_next     = ALLOCATE;
      end
      ALLOCATE: begin
        mem_address = {req_tag, req_index, {OFFSET_W{1'b0}}};
        wr_line_en  = 1'b1;
        state_next  = COMPARE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic first_compare;

  // Marks the first COMPARE of each request so the post-refill hit is not counted again.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      first_compare <= 1'b0;
    end else if (state == IDLE && cpu_req) begin
      first_compare <= 1'b1;
    end else if (state == COMPARE) begin
      first_compare <= 1'b0;
    end
  end

  // Saturating hit/miss counters, one increment per request.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == COMPARE && first_compare) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: behavioural cache/memory model, directed plan plus random traffic.
// Latency: checks hit/clean-miss/dirty-miss ready cycles against the model.
// Backpressure: holds cpu_req until cpu_ready, as a CPU would.
module tb_cache_controller;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         cpu_req;
  logic         cpu_write;
  logic [9:0]   cpu_address;
  logic [31:0]  cpu_write_data;
  logic [31:0]  cpu_read_data;
  logic         cpu_ready;
  logic         mem_read_write;
  logic [9:0]   mem_address;
  logic [127:0] mem_write_data;
  logic [127:0] mem_read_data;
`ifdef CACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Main memory model (written only by the monitor process).
  logic [31:0]  tb_mem [64][4];
  int           wb_events = 0;
  int           rw_long = 0;
  int           wb_unstable = 0;
  logic [9:0]   last_wb_addr = '0;
  logic [127:0] last_wb_data = '0;

  // Reference model: what the cache should hold and what memory should hold.
  bit           m_valid [4];
  bit           m_dirty [4];
  logic [3:0]   m_tag [4];
  logic [31:0]  m_data [4][4];
  logic [31:0]  ref_mem [64][4];
  int           m_hits = 0;
  int           m_misses = 0;

  always #5 clock = ~clock;

  cache_controller #(.LINES(4)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpu_req        (cpu_req),
    .cpu_write      (cpu_write),
    .cpu_address    (cpu_address),
    .cpu_write_data (cpu_write_data),
    .cpu_read_data  (cpu_read_data),
    .cpu_ready      (cpu_ready),
    .mem_read_write (mem_read_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef CACHE_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  // Combinational block read, word 0 in the low bits.
  assign mem_read_data = {tb_mem[mem_address[9:4]][3], tb_mem[mem_address[9:4]][2],
                          tb_mem[mem_address[9:4]][1], tb_mem[mem_address[9:4]][0]};

  function automatic logic [31:0] init_word(input int b, input int w);
    if (b == 4) return 32'h11111111 * (w + 1);
    return 32'(32'hA000_0000 | (b << 8) | w);
  endfunction

  // Memory: writes the block on each 0->1 of mem_read_write; also watches pulse width and stability.
  initial begin
    bit prev_rw;
    logic [5:0] blk;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        tb_mem[b][w] = init_word(b, w);
    prev_rw = 1'b0;
    forever begin
      @(negedge clock);
      if (mem_read_write && !prev_rw) begin
        blk = mem_address[9:4];
        for (int w = 0; w < 4; w++)
          tb_mem[blk][w] = mem_write_data[127-32*w -: 32];
        wb_events++;
        last_wb_addr = mem_address;
        last_wb_data = mem_write_data;
      end
      if (mem_read_write && prev_rw) rw_long++;
      if (!mem_read_write && prev_rw && reset_n &&
          (mem_address !== last_wb_addr || mem_write_data !== last_wb_data))
        wb_unstable++;
      prev_rw = mem_read_write;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits = 0;
    m_misses = 0;
  endtask

  // Applies one request to the model, drives it, and checks the DUT against the model.
  task automatic do_req(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                        input bit scramble, input string name);
    logic [1:0]  idx;
    logic [3:0]  tg;
    logic [1:0]  w;
    logic [5:0]  vblk;
    logic [9:0]  exp_wb_addr;
    logic [31:0] exp_rd;
    logic [31:0] got_rd;
    bit          hit;
    bit          exp_wb;
    bit          blk_ok;
    int          exp_lat;
    int          lat;
    int          wb0;
    idx = addr[5:4];
    tg  = addr[9:6];
    w   = addr[3:2];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb = !hit && m_valid[idx] && m_dirty[idx];
    exp_lat = hit ? 1 : (exp_wb ? 5 : 3);
    vblk = {m_tag[idx], idx};
    exp_wb_addr = {m_tag[idx], idx, 4'b0};
    if (hit) m_hits++; else m_misses++;
    if (!hit) begin
      if (exp_wb)
        for (int i = 0; i < 4; i++) ref_mem[vblk][i] = m_data[idx][i];
      for (int i = 0; i < 4; i++) m_data[idx][i] = ref_mem[{tg, idx}][i];
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_data[idx][w];
    if (wr) begin
      m_data[idx][w] = data;
      m_dirty[idx] = 1'b1;
    end

    wb0 = wb_events;
    cpu_req = 1'b1;
    cpu_write = wr;
    cpu_address = addr;
    cpu_write_data = data;
    @(posedge clock);
    #1;
    if (scramble) begin
      cpu_address = 10'($urandom);
      cpu_write = 1'($urandom);
      cpu_write_data = $urandom;
    end
    lat = 0;
    got_rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      if (cpu_ready) begin
        lat = c;
        got_rd = cpu_read_data;
        break;
      end
    end
    @(posedge clock);
    #1;
    cpu_req = 1'b0;

    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d (0 = timeout)", name, lat, exp_lat);
    end
    if (!wr) begin
      checks++;
      if (got_rd !== exp_rd) begin
        errors++;
        $display("FAIL %s read_data: got %h expected %h", name, got_rd, exp_rd);
      end
    end
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_pulse: got %b expected 0 the cycle after ready", name, cpu_ready);
    end
    checks++;
    if (wb_events - wb0 !== int'(exp_wb)) begin
      errors++;
      $display("FAIL %s writeback_count: got %0d expected %0d", name, wb_events - wb0, exp_wb);
    end
    if (exp_wb) begin
      checks++;
      if (last_wb_addr !== exp_wb_addr) begin
        errors++;
        $display("FAIL %s writeback_addr: got %h expected %h", name, last_wb_addr, exp_wb_addr);
      end
      blk_ok = 1'b1;
      for (int i = 0; i < 4; i++)
        if (tb_mem[vblk][i] !== ref_mem[vblk][i]) blk_ok = 1'b0;
      checks++;
      if (!blk_ok) begin
        errors++;
        $display("FAIL %s writeback_block: memory block %h differs from expected victim data", name, vblk);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    cpu_write = 1'b0;
    cpu_address = '0;
    cpu_write_data = '0;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset cpu_ready: got %b expected 0", cpu_ready); end
    checks++;
    if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL reset cpu_read_data: got %h expected 0", cpu_read_data); end
    checks++;
    if (mem_read_write !== 1'b0) begin errors++; $display("FAIL reset mem_read_write: got %b expected 0", mem_read_write); end
    checks++;
    if (mem_address !== 10'h0) begin errors++; $display("FAIL reset mem_address: got %h expected 0", mem_address); end
    checks++;
    if (mem_write_data !== 128'h0) begin errors++; $display("FAIL reset mem_write_data: got %h expected 0", mem_write_data); end
    reset_n = 1'b1;
  endtask

  task automatic test_plan_sequence();
    do_req(1'b0, 10'h040, 32'h0, 1'b0, "cold_miss_040");
    do_req(1'b0, 10'h044, 32'h0, 1'b0, "hit_044");
    do_req(1'b1, 10'h048, 32'hDEADBEEF, 1'b0, "store_hit_048");
    checks++;
    if (tb_mem[4][2] !== 32'h33333333) begin
      errors++;
      $display("FAIL mem_unchanged_048: got %h expected 33333333", tb_mem[4][2]);
    end
    do_req(1'b0, 10'h148, 32'h0, 1'b0, "dirty_miss_148");
    checks++;
    if (last_wb_data[63:32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_word2_position: got %h expected deadbeef", last_wb_data[63:32]);
    end
    checks++;
    if (tb_mem[4][2] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_after_wb_048: got %h expected deadbeef", tb_mem[4][2]);
    end
    do_req(1'b0, 10'h080, 32'h0, 1'b0, "clean_miss_080");
    do_req(1'b0, 10'h0C0, 32'h0, 1'b0, "clean_miss_0c0");
    // Store to the line just refilled must merge with refilled data.
    do_req(1'b1, 10'h0C4, 32'h12345678, 1'b0, "store_after_refill");
    do_req(1'b0, 10'h0C0, 32'h0, 1'b0, "reread_0c0");
    do_req(1'b0, 10'h0C4, 32'h0, 1'b0, "reread_0c4");
  endtask

  task automatic test_random_traffic();
    logic [9:0] addr;
    for (int n = 0; n < 200; n++) begin
      addr = {4'($urandom_range(0, 3)), 2'($urandom), 2'($urandom), 2'($urandom)};
      do_req(1'($urandom), addr, $urandom, 1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_writeback();
    bit   saw_wb;
    bit   blk_ok;
    logic [5:0] vblk;
    do_req(1'b1, 10'h000, 32'hCAFEF00D, 1'b0, "prep_dirty_000");
    vblk = {m_tag[0], 2'd0};
    cpu_req = 1'b1;
    cpu_write = 1'b0;
    cpu_address = 10'h100;
    cpu_write_data = '0;
    @(posedge clock);
    saw_wb = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (mem_read_write) begin
        saw_wb = 1'b1;
        break;
      end
    end
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (!saw_wb) begin errors++; $display("FAIL midwb_reach_writeback: got none expected a write-back within 8 cycles"); end
    checks++;
    if (mem_read_write !== 1'b0) begin errors++; $display("FAIL midwb_rw_drop: got %b expected 0", mem_read_write); end
    checks++;
    if (mem_address !== 10'h0) begin errors++; $display("FAIL midwb_addr: got %h expected 0", mem_address); end
    checks++;
    if (cpu_ready !== 1'b0) begin errors++; $display("FAIL midwb_ready: got %b expected 0", cpu_ready); end
    cpu_req = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    // The 0->1 strobe already happened, so the victim reached memory; everything else is dropped.
    for (int i = 0; i < 4; i++) ref_mem[vblk][i] = m_data[0][i];
    model_reset();
    blk_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (tb_mem[vblk][i] !== ref_mem[vblk][i]) blk_ok = 1'b0;
    checks++;
    if (!blk_ok) begin errors++; $display("FAIL midwb_victim_mem: memory block %h differs from expected", vblk); end
    do_req(1'b0, 10'h040, 32'h0, 1'b0, "reload_040_after_reset");
    do_req(1'b0, 10'h100, 32'h0, 1'b0, "load_100_after_reset");
    do_req(1'b0, 10'h100, 32'h0, 1'b0, "hit_100_after_reset");
  endtask

  task automatic test_monitors();
    checks++;
    if (rw_long !== 0) begin errors++; $display("FAIL rw_pulse_width: got %0d long pulses expected 0", rw_long); end
    checks++;
    if (wb_unstable !== 0) begin errors++; $display("FAIL wb_stability: got %0d unstable releases expected 0", wb_unstable); end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_count !== 16'(m_hits)) begin errors++; $display("FAIL hit_count: got %0d expected %0d", hit_count, m_hits); end
    checks++;
    if (miss_count !== 16'(m_misses)) begin errors++; $display("FAIL miss_count: got %0d expected %0d", miss_count, m_misses); end
`endif
  endtask

  initial begin
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        ref_mem[b][w] = init_word(b, w);
    test_reset();
    test_plan_sequence();
    test_random_traffic();
    test_monitors();
    test_reset_mid_writeback();
    test_random_traffic();
    test_monitors();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
